// File: rtl/sub_pkg.sv
// Shared types for the chunked multi-cycle subtractor (sub_seq_chunked).
package sub_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP = 2'd0,
    MODE_SAT  = 2'd1,
    MODE_ABS  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SWAP = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sub_chunk.sv
// One CHUNK-bit slice of the subtract: {bout, diff} = a - b - bin.
module sub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] diff,
  output logic             bout
);

  assign {bout, diff} = {1'b0, a} - {1'b0, b} - (CHUNK+1)'(bin);

endmodule

// File: rtl/sub_seq_chunked.sv
// Multi-cycle unsigned subtractor, CHUNK bits per cycle with a registered borrow chain.
// Optional SUB_BORROW_CNT_EN adds a saturating count of borrowing output handshakes.
module sub_seq_chunked
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g_vec,
  input  logic [WIDTH-1:0] l_vec,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_v,
  output logic             borrow,
  output logic             zero
`ifdef SUB_BORROW_CNT_EN
  ,
  output logic [15:0]      borrow_cnt
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("sub_seq_chunked: WIDTH must be a multiple of CHUNK");
  end

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic             bin;
  logic             borrow_r;
  logic [WIDTH-1:0] g_r;
  logic [WIDTH-1:0] l_r;
  logic [WIDTH-1:0] acc;
  mode_e            mode_r;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] d_c;
  logic             bout_c;
  logic [WIDTH-1:0] res;

  // SAT clamps a borrowing result to zero; ABS already holds l-g after SWAP.
  function automatic logic [WIDTH-1:0] final_result(input logic [WIDTH-1:0] diff,
                                                    input logic brw, input mode_e m);
    return (m == MODE_SAT && brw) ? '0 : diff;
  endfunction

  always_comb begin
    a_c = g_r[int'(idx)*CHUNK +: CHUNK];
    b_c = l_r[int'(idx)*CHUNK +: CHUNK];
    if (state == S_SWAP) begin
      a_c = l_r[int'(idx)*CHUNK +: CHUNK];
      b_c = g_r[int'(idx)*CHUNK +: CHUNK];
    end
  end

  sub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_c),
    .b    (b_c),
    .bin  (bin),
    .diff (d_c),
    .bout (bout_c)
  );

  assign res = final_result(acc, borrow_r, mode_r);

  // Operand capture and partial-result accumulation (data path, not reset)
  always_ff @(posedge clk) begin
    if (state == S_IDLE && in_valid && in_ready) begin
      g_r    <= g_vec;
      l_r    <= l_vec;
      mode_r <= mode_e'(mode);
    end
    if (state == S_CALC || state == S_SWAP)
      acc[int'(idx)*CHUNK +: CHUNK] <= d_c;
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_v     <= '0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
      idx       <= '0;
      bin       <= 1'b0;
      borrow_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            state    <= S_CALC;
            in_ready <= 1'b0;
            idx      <= '0;
            bin      <= 1'b0;
          end
        end
        S_CALC, S_SWAP: begin
          bin <= bout_c;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            idx <= '0;
            bin <= 1'b0;
            if (state == S_CALC)
              borrow_r <= bout_c;
            if (state == S_CALC && mode_r == MODE_ABS && bout_c)
              state <= S_SWAP;
            else
              state <= S_DONE;
          end
        end
        S_DONE: begin
          // First DONE cycle publishes the result; outputs then hold until taken.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_v     <= res;
            borrow    <= borrow_r;
            zero      <= (res == '0);
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SUB_BORROW_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      borrow_cnt <= '0;
    else if (state == S_DONE && out_valid && out_ready && borrow && borrow_cnt != 16'hFFFF)
      borrow_cnt <= borrow_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sub_seq_chunked.sv
// Directed self-checking bench for sub_seq_chunked (8/4 instance plus a 16/4 instance).
module tb_sub_seq_chunked;
  import sub_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, borrow, zero;
  logic [7:0]  g_vec, l_vec, out_v;
  logic [1:0]  mode;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_borrow, b_zero;
  logic [15:0] b_g_vec, b_l_vec, b_out_v;
  logic [1:0]  b_mode;
`ifdef SUB_BORROW_CNT_EN
  logic [15:0] borrow_cnt, b_borrow_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  logic seen;

  sub_seq_chunked #(.WIDTH(8), .CHUNK(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .g_vec(g_vec), .l_vec(l_vec), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_v(out_v), .borrow(borrow), .zero(zero)
`ifdef SUB_BORROW_CNT_EN
    , .borrow_cnt(borrow_cnt)
`endif
  );

  sub_seq_chunked #(.WIDTH(16), .CHUNK(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .g_vec(b_g_vec), .l_vec(b_l_vec), .mode(b_mode), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_v(b_out_v), .borrow(b_borrow), .zero(b_zero)
`ifdef SUB_BORROW_CNT_EN
    , .borrow_cnt(b_borrow_cnt)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accept one operation on dut_a, scramble inputs, return cycles until out_valid (capped at 20).
  task automatic op_a(input logic [1:0] m, input logic [7:0] g, input logic [7:0] l,
                      output int cycles);
    @(negedge clk);
    in_valid = 1'b1; mode = m; g_vec = g; l_vec = l;
    chk1("in_ready_idle", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; g_vec = 8'($urandom); l_vec = 8'($urandom); mode = 2'($urandom);
    chk1("in_ready_busy", in_ready, 1'b0);
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (out_valid) break;
    end
  endtask

  task automatic ack_a();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk1("out_valid_after_ack", out_valid, 1'b0);
    chk1("in_ready_after_ack", in_ready, 1'b1);
  endtask

  task automatic op_b(input logic [1:0] m, input logic [15:0] g, input logic [15:0] l,
                      output int cycles);
    @(negedge clk);
    b_in_valid = 1'b1; b_mode = m; b_g_vec = g; b_l_vec = l;
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_g_vec = 16'($urandom); b_l_vec = 16'($urandom);
    cycles = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (b_out_valid) break;
    end
  endtask

  task automatic ack_b();
    @(negedge clk);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    chk1("b_out_valid_after_ack", b_out_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; g_vec = '0; l_vec = '0; mode = 2'd0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_g_vec = '0; b_l_vec = '0; b_mode = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk8("rst_out_v", out_v, 8'd0);
    chk1("rst_borrow", borrow, 1'b0);
    chk1("rst_zero", zero, 1'b0);

    op_a(2'd0, 8'd10, 8'd5, lat);
    chki("wrap_10_5_lat", lat, 3);
    chk8("wrap_10_5_out", out_v, 8'd5);
    chk1("wrap_10_5_borrow", borrow, 1'b0);
    chk1("wrap_10_5_zero", zero, 1'b0);
    ack_a();

    op_a(2'd0, 8'd25, 8'd7, lat);
    chk8("wrap_25_7_out", out_v, 8'd18);
    chk1("wrap_25_7_borrow", borrow, 1'b0);
    ack_a();

    op_a(2'd0, 8'd5, 8'd10, lat);
    chk8("wrap_5_10_out", out_v, 8'd251);
    chk1("wrap_5_10_borrow", borrow, 1'b1);
    chk1("wrap_5_10_zero", zero, 1'b0);
    ack_a();

    op_a(2'd1, 8'd5, 8'd10, lat);
    chk8("sat_5_10_out", out_v, 8'd0);
    chk1("sat_5_10_borrow", borrow, 1'b1);
    chk1("sat_5_10_zero", zero, 1'b1);
    ack_a();

    op_a(2'd1, 8'd200, 8'd55, lat);
    chk8("sat_200_55_out", out_v, 8'd145);
    chk1("sat_200_55_borrow", borrow, 1'b0);
    ack_a();

    op_a(2'd2, 8'd5, 8'd10, lat);
    chki("abs_5_10_lat", lat, 5);
    chk8("abs_5_10_out", out_v, 8'd5);
    chk1("abs_5_10_borrow", borrow, 1'b1);
    ack_a();

    op_a(2'd0, 8'd0, 8'd255, lat);
    chk8("wrap_0_255_out", out_v, 8'd1);
    chk1("wrap_0_255_borrow", borrow, 1'b1);
    ack_a();

    op_a(2'd2, 8'd0, 8'd255, lat);
    chk8("abs_0_255_out", out_v, 8'd255);
    ack_a();

    op_a(2'd3, 8'd5, 8'd10, lat);
    chk8("rsvd_5_10_out", out_v, 8'd251);
    chk1("rsvd_5_10_borrow", borrow, 1'b1);
    ack_a();

    op_a(2'd2, 8'd7, 8'd7, lat);
    chki("abs_7_7_lat", lat, 3);
    chk8("abs_7_7_out", out_v, 8'd0);
    chk1("abs_7_7_zero", zero, 1'b1);
    chk1("abs_7_7_borrow", borrow, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; g_vec = 8'd1; l_vec = 8'd2; mode = 2'd0;
      chk1("hold_out_valid", out_valid, 1'b1);
      chk8("hold_out_v", out_v, 8'd0);
      chk1("hold_zero", zero, 1'b1);
      chk1("hold_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    ack_a();

    // Reset pulse in the middle of CALC
    @(negedge clk);
    in_valid = 1'b1; g_vec = 8'd50; l_vec = 8'd20; mode = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("midrst_in_ready", in_ready, 1'b1);
    chk1("midrst_out_valid", out_valid, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    chk1("midrst_no_result", seen, 1'b0);

    op_a(2'd0, 8'd200, 8'd100, lat);
    chk8("wrap_200_100_out", out_v, 8'd100);
    chk1("wrap_200_100_borrow", borrow, 1'b0);
    ack_a();

    op_a(2'd0, 8'd3, 8'd4, lat);
    chk8("wrap_3_4_out", out_v, 8'd255);
    ack_a();
    op_a(2'd1, 8'd1, 8'd2, lat);
    chk8("sat_1_2_out", out_v, 8'd0);
    ack_a();
    op_a(2'd2, 8'd1, 8'd200, lat);
    chk8("abs_1_200_out", out_v, 8'd199);
    ack_a();
`ifdef SUB_BORROW_CNT_EN
    chk16("borrow_cnt", borrow_cnt, 16'd3);
`endif

    op_b(2'd0, 16'd1000, 16'd1, lat);
    chki("b_wrap_lat", lat, 5);
    chk16("b_wrap_1000_1_out", b_out_v, 16'd999);
    chk1("b_wrap_1000_1_borrow", b_borrow, 1'b0);
    ack_b();
    op_b(2'd2, 16'd1, 16'd1000, lat);
    chki("b_abs_lat", lat, 9);
    chk16("b_abs_1_1000_out", b_out_v, 16'd999);
    chk1("b_abs_1_1000_borrow", b_borrow, 1'b1);
    chk1("b_abs_1_1000_zero", b_zero, 1'b0);
    ack_b();
`ifdef SUB_BORROW_CNT_EN
    chk16("b_borrow_cnt", b_borrow_cnt, 16'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
